prog_mem_loader: RTL

Parametrised instruction memory for the accumulator CPU, with a byte-serial boot loader and a registered fetch port.
- Replaces the fixed single-port program memory.
- The loader streams a program image from the UART/debug path into the array, starting at word 0, then releases the array to the fetch stage.
- Fetch has one-cycle registered latency with a valid strobe, so the control unit can stall cleanly while a load is in progress.

---
 rtl/prog_mem_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// Instruction memory for the accumulator CPU: byte-serial boot loader plus a registered fetch port.
// Optional feature: define PARITY_EN to store an even-parity bit per word and flag mismatches on fetch.
module prog_mem_loader #(
    parameter int    ADDR_LENGTH = 11,
    parameter int    DATA_LENGTH = 16,
    parameter string PROGRAM     = ""
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_req,
    input  logic [ADDR_LENGTH-1:0] fetch_addr,
    output logic [DATA_LENGTH-1:0] instruction,
    output logic                   fetch_valid,
    input  logic                   load_start,
    input  logic [ADDR_LENGTH:0]   load_len,
    input  logic                   load_byte_valid,
    input  logic [7:0]             load_byte,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   parity_err
);

    // state   | meaning
    // S_IDLE  | array owned by fetch; waits for load_start
    // S_LOAD  | assembling bytes of the current word, MSB first
    // S_WRITE | one-cycle write of the assembled word, incoming bytes dropped
    // S_DONE  | one-cycle load_done pulse, fetch still blocked

    localparam int DEPTH = 2 ** ADDR_LENGTH;
    localparam int BYTES = DATA_LENGTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef PARITY_EN
    localparam int MW = DATA_LENGTH + 1;
`else
    localparam int MW = DATA_LENGTH;
`endif

    localparam logic [ADDR_LENGTH:0] LEN_MAX   = (ADDR_LENGTH + 1)'(DEPTH);
    localparam logic [ADDR_LENGTH:0] LEN_ONE   = (ADDR_LENGTH + 1)'(1);
    localparam logic [BCW-1:0]       BYTE_LAST = BCW'(BYTES - 1);
    localparam logic [BCW-1:0]       BYTE_ONE  = BCW'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
    typedef logic [MW-1:0] mem_t [DEPTH];

    function automatic mem_t init_image();
        logic [DATA_LENGTH-1:0] img [DEPTH];
        mem_t                   m;
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        img[0] = DATA_LENGTH'(16'h1001);
        img[1] = DATA_LENGTH'(16'h2002);
        img[2] = DATA_LENGTH'(16'h0800);
        img[3] = DATA_LENGTH'(16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef PARITY_EN
            m[i] = {^img[i], img[i]};
`else
            m[i] = img[i];
`endif
        end
        return m;
    endfunction

    // Power-up image only; the array is deliberately never touched by reset.
    mem_t mem = init_image();

    state_t                 state, state_next;
    logic [ADDR_LENGTH:0]   len;
    logic [ADDR_LENGTH:0]   word_cnt;
    logic [BCW-1:0]         byte_cnt;
    logic [DATA_LENGTH-1:0] asm_word;
    logic [MW-1:0]          wr_word;
    logic [MW-1:0]          rd_word;
    logic                   start_ok;
    logic                   byte_last;
    logic                   fetch_en;

    assign start_ok  = load_start && (load_len != '0);
    assign byte_last = load_byte_valid && (byte_cnt == BYTE_LAST);
    assign fetch_en  = fetch_req && (state == S_IDLE);
    assign load_busy = (state == S_LOAD) || (state == S_WRITE);
    assign load_done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_LOAD;
            S_LOAD:  if (byte_last) state_next = S_WRITE;
            S_WRITE: state_next = (word_cnt == len - LEN_ONE) ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_ok) begin
                    len      <= (load_len > LEN_MAX) ? LEN_MAX : load_len;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                end
                S_LOAD: if (load_byte_valid) begin
                    asm_word <= (asm_word << 8) | DATA_LENGTH'(load_byte);
                    byte_cnt <= byte_cnt + BYTE_ONE;
                end
                S_WRITE: begin
                    byte_cnt <= '0;
                    word_cnt <= word_cnt + LEN_ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef PARITY_EN
    assign wr_word = {^asm_word, asm_word};
`else
    assign wr_word = asm_word;
`endif

    always_ff @(posedge clk) begin
        if (state == S_WRITE) mem[word_cnt[ADDR_LENGTH-1:0]] <= wr_word;
    end

    assign rd_word = mem[fetch_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= '0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_en;
            if (fetch_en) instruction <= rd_word[DATA_LENGTH-1:0];
        end
    end

`ifdef PARITY_EN
    // XOR over data plus stored bit is the recomputed-vs-stored comparison in one step.
    logic parity_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        parity_q <= 1'b0;
        else if (fetch_en) parity_q <= ^rd_word;
    end
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
